// File: rtl/pdp8_iot_ctl_pkg.sv
// Shared types and constants for the PDP-8 IOT sequencer: FSM states, phase
// codes, the internal device number and IOP bit positions within ir.
package pdp8_iot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P4,
    S_DONE
  } iot_state_t;

  localparam logic [3:0] PH_IOP1 = 4'h1;
  localparam logic [3:0] PH_IOP2 = 4'h2;
  localparam logic [3:0] PH_IOP4 = 4'h4;

  localparam logic [5:0] DEV_INTERNAL = 6'o00;

  localparam int IOP1_BIT = 0;
  localparam int IOP2_BIT = 1;
  localparam int IOP4_BIT = 2;

  // First enabled phase in P1, P2, P4 order; DONE when nothing is left.
  function automatic iot_state_t first_phase(input logic [2:0] en);
    if (en[IOP1_BIT]) return S_P1;
    if (en[IOP2_BIT]) return S_P2;
    if (en[IOP4_BIT]) return S_P4;
    return S_DONE;
  endfunction

  function automatic logic [3:0] phase_code(input iot_state_t s);
    case (s)
      S_P1:    return PH_IOP1;
      S_P2:    return PH_IOP2;
      S_P4:    return PH_IOP4;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/pdp8_iot_ctl_if.sv
// CPU and device-bus signals of the IOT sequencer, grouped as one interface.
// master = the sequencer, slave = CPU/device side.
interface pdp8_iot_ctl_if;
  logic        start;
  logic [11:0] ir;
  logic [11:0] ac_in;
  logic        instr_done;
  logic [11:0] io_data_out;
  logic        io_data_avail;
  logic        io_skip;
  logic        io_clear_ac;
  logic        io_interrupt;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [5:0]  io_select;
  logic [11:0] io_data_in;
  logic [11:0] ac_out;
  logic        ac_load;
  logic        skip;
  logic        busy;
  logic        int_req;

  modport master (
    input  start, ir, ac_in, instr_done, io_data_out, io_data_avail,
           io_skip, io_clear_ac, io_interrupt,
    output iot, state, mb, io_select, io_data_in, ac_out, ac_load, skip,
           busy, int_req
  );

  modport slave (
    output start, ir, ac_in, instr_done, io_data_out, io_data_avail,
           io_skip, io_clear_ac, io_interrupt,
    input  iot, state, mb, io_select, io_data_in, ac_out, ac_load, skip,
           busy, int_req
  );
endinterface

// File: rtl/pdp8_iot_ctl_ion.sv
// Interrupt-enable flip-flop with its one-instruction turn-on delay and the
// gated interrupt request.
module pdp8_iot_ion (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_ac_load,
  input  logic i_instr_done,
  input  logic i_interrupt,
  output logic o_ion,
  output logic o_int_req
);
  logic r_ion, r_delay, r_armed;

  // r_armed marks that the ION instruction has finished, so only a later
  // instr_done ends the delay window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ion   <= 1'b0;
      r_delay <= 1'b0;
      r_armed <= 1'b0;
    end else if (i_clr) begin
      r_ion   <= 1'b0;
      r_delay <= 1'b0;
      r_armed <= 1'b0;
    end else if (i_set) begin
      r_ion   <= 1'b1;
      r_delay <= 1'b1;
      r_armed <= 1'b0;
    end else if (r_delay) begin
      if (r_armed && i_instr_done) begin
        r_delay <= 1'b0;
        r_armed <= 1'b0;
      end else if (i_ac_load) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_ion     = r_ion;
  assign o_int_req = r_ion & i_interrupt & ~r_delay;
endmodule

// File: rtl/pdp8_iot_ctl.sv
// PDP-8 IOT sequencer: steps IOP1/IOP2/IOP4 phases, merges device replies into AC.
// Define IOT_SKON_EN to make device 00 / 6000 act as SKON.
module pdp8_iot_ctl
  import pdp8_iot_pkg::*;
#(
  parameter int IOP_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  pdp8_iot_ctl_if.master bus
);
  localparam logic [3:0] CNT_LAST = 4'(IOP_CYCLES - 1);
  localparam logic [3:0] CNT_GAP  = 4'(IOP_CYCLES);

  iot_state_t  r_state, w_state_next, w_after;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [11:0] r_mb, r_ac, r_ac_out, w_ac_sampled;
  logic [5:0]  r_sel;
  logic        r_skip_acc, r_skip, r_ac_load;
  logic        w_in_phase, w_active, w_sample, w_internal, w_skon;
  logic        w_ion, w_ion_set, w_ion_clr, w_int_req;

  assign w_internal = (r_sel == DEV_INTERNAL);
  assign w_in_phase = (r_state == S_P1) || (r_state == S_P2) || (r_state == S_P4);
  assign w_active   = w_in_phase && (r_cnt < CNT_GAP);
  assign w_sample   = w_in_phase && (r_cnt == CNT_LAST);
`ifdef IOT_SKON_EN
  assign w_skon = w_internal && (r_mb[2:0] == 3'b000);
`else
  assign w_skon = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A phase lasts IOP_CYCLES active clocks plus one idle gap; after the last
  // phase the gap is replaced by the DONE cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_P1:    w_after = first_phase(r_mb[2:0] & 3'b110);
      S_P2:    w_after = first_phase(r_mb[2:0] & 3'b100);
      default: w_after = S_DONE;
    endcase
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = first_phase(bus.ir[2:0]);
          w_cnt_next   = '0;
        end
      end
      S_P1, S_P2, S_P4: begin
        if (w_sample && (w_after == S_DONE)) begin
          w_state_next = S_DONE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_GAP) begin
          w_state_next = w_after;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Clear is applied before the OR so a same-cycle clear+data yields the data.
  assign w_ac_sampled = (bus.io_clear_ac ? 12'o0000 : r_ac)
                      | (bus.io_data_avail ? bus.io_data_out : 12'o0000);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mb       <= '0;
      r_sel      <= '0;
      r_ac       <= '0;
      r_ac_out   <= '0;
      r_skip_acc <= 1'b0;
      r_skip     <= 1'b0;
      r_ac_load  <= 1'b0;
    end else begin
      r_ac_load <= 1'b0;
      if ((r_state == S_IDLE) && bus.start) begin
        r_mb       <= bus.ir;
        r_sel      <= bus.ir[8:3];
        r_ac       <= bus.ac_in;
        r_skip_acc <= 1'b0;
      end
      if (w_sample && !w_internal) begin
        r_ac       <= w_ac_sampled;
        r_skip_acc <= r_skip_acc | bus.io_skip;
      end
      if (r_state == S_DONE) begin
        r_ac_out  <= r_ac;
        r_skip    <= r_skip_acc | (w_skon & w_ion);
        r_ac_load <= 1'b1;
      end
    end
  end

  assign w_ion_set = w_sample && w_internal && (r_state == S_P1);
  assign w_ion_clr = (w_sample && w_internal && (r_state == S_P2))
                   || ((r_state == S_DONE) && w_skon);

  pdp8_iot_ion u_ion (
    .clk          (clk),
    .rst_n        (reset),
    .i_set        (w_ion_set),
    .i_clr        (w_ion_clr),
    .i_ac_load    (r_ac_load),
    .i_instr_done (bus.instr_done),
    .i_interrupt  (bus.io_interrupt),
    .o_ion        (w_ion),
    .o_int_req    (w_int_req)
  );

  assign bus.iot        = w_active && !w_internal;
  assign bus.state      = w_active ? phase_code(r_state) : 4'h0;
  assign bus.mb         = r_mb;
  assign bus.io_select  = r_sel;
  assign bus.io_data_in = r_ac;
  assign bus.ac_out     = r_ac_out;
  assign bus.ac_load    = r_ac_load;
  assign bus.skip       = r_skip;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.int_req    = w_int_req;
endmodule

// File: tb/tb_pdp8_iot_ctl.sv
// Bench for pdp8_iot_ctl: vector table, hand-written ION/reset/SKON sequences
// and randomized IOTs checked against a phase-list reference model.
module tb_pdp8_iot_ctl;
  localparam int IOP = 2;
  localparam int TMO = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pdp8_iot_ctl_if bus ();

  pdp8_iot_ctl #(.IOP_CYCLES(IOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] ir;
    logic [11:0] ac;
    logic [2:0]  clr;
    logic [2:0]  av;
    logic [2:0]  skp;
    logic [11:0] d0;
    logic [11:0] d1;
    logic [11:0] d2;
    logic [11:0] e_ac;
    logic        e_sk;
    int          e_lat;
  } vec_t;

  vec_t        tbl [6];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  rsp_clr, rsp_av, rsp_skp;
  logic [11:0] rsp_data [0:2];
  logic [3:0]  st_log [0:63];
  logic        iot_log [0:63];
  logic        irq_log [0:63];
  logic        busy_log [0:63];
  int          got_lat;
  logic [11:0] got_ac, got_mb;
  logic [5:0]  got_sel;
  logic        got_sk;
  logic        ion_m, delay_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive_rsp(input logic [3:0] st);
    int p;
    p = (st == 4'h1) ? 0 : (st == 4'h2) ? 1 : (st == 4'h4) ? 2 : -1;
    if (p < 0) begin
      bus.io_clear_ac = 1'b0; bus.io_data_avail = 1'b0;
      bus.io_skip = 1'b0; bus.io_data_out = 12'o0;
    end else begin
      bus.io_clear_ac = rsp_clr[p]; bus.io_data_avail = rsp_av[p];
      bus.io_skip = rsp_skp[p]; bus.io_data_out = rsp_data[p];
    end
  endtask

  // mode: 0 no instr_done, 1 instr_done with ac_load, 2 instr_done the cycle after
  task automatic run_iot(input logic [11:0] t_ir, input logic [11:0] t_ac, input int mode);
    @(negedge clk);
    bus.start = 1'b1; bus.ir = t_ir; bus.ac_in = t_ac;
    @(negedge clk);
    bus.start = 1'b0; bus.ir = 12'($urandom); bus.ac_in = 12'($urandom);
    got_lat = -1;
    for (int k = 1; k <= TMO; k++) begin
      st_log[k] = bus.state; iot_log[k] = bus.iot;
      irq_log[k] = bus.int_req; busy_log[k] = bus.busy;
      drive_rsp(bus.state);
      if (bus.ac_load) begin
        got_lat = k; got_ac = bus.ac_out; got_sk = bus.skip;
        got_sel = bus.io_select; got_mb = bus.mb;
        bus.instr_done = (mode == 1);
        @(negedge clk);
        bus.instr_done = (mode == 2);
        @(negedge clk);
        bus.instr_done = 1'b0;
        break;
      end
      @(negedge clk);
    end
    drive_rsp(4'h0);
  endtask

  task automatic check_txn(input string tag, input logic [11:0] t_ir, input logic [11:0] e_ac,
                           input logic e_sk, input int e_lat);
    logic [3:0] e_st [0:63];
    int k, bad;
    logic ext;
    k = 1; bad = 0; ext = (t_ir[8:3] != 6'o00);
    for (int p = 0; p < 3; p++) begin
      if (t_ir[p]) begin
        for (int j = 0; j < IOP; j++) begin e_st[k] = 4'(1 << p); k++; end
        e_st[k] = 4'h0; k++;
      end
    end
    if (k == 1) e_st[1] = 4'h0;
    for (int c = 1; c < e_lat; c++) begin
      if (st_log[c] !== e_st[c] || iot_log[c] !== (ext && e_st[c] != 4'h0) || busy_log[c] !== 1'b1)
        bad++;
    end
    if (busy_log[e_lat] !== 1'b0) bad++;
    check({tag, " latency"}, got_lat, e_lat);
    check({tag, " ac_out"}, got_ac, e_ac);
    check({tag, " skip"}, got_sk, e_sk);
    check({tag, " io_select"}, got_sel, t_ir[8:3]);
    check({tag, " mb"}, got_mb, t_ir);
    check({tag, " phase sequence errors"}, bad, 0);
    $display("txn %s ir=%o ac_out=%o skip=%0d lat=%0d", tag, t_ir, got_ac, got_sk, got_lat);
  endtask

  // Reference: walk the enabled phases in order and apply the device rules.
  task automatic model(input logic [11:0] t_ir, input logic [11:0] t_ac, input int mode,
                       output logic [11:0] e_ac, output logic e_sk, output int e_lat);
    int n;
    logic internal, is_ion;
    n = 0; internal = (t_ir[8:3] == 6'o00); is_ion = 1'b0;
    e_ac = t_ac; e_sk = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (t_ir[p]) begin
        n++;
        if (!internal) begin
          if (rsp_clr[p]) e_ac = 12'o0;
          if (rsp_av[p]) e_ac = e_ac | rsp_data[p];
          e_sk = e_sk | rsp_skp[p];
        end
      end
    end
    if (internal) begin
      if (t_ir[0]) begin ion_m = 1'b1; delay_m = 1'b1; is_ion = 1'b1; end
      if (t_ir[1]) begin ion_m = 1'b0; delay_m = 1'b0; is_ion = 1'b0; end
`ifdef IOT_SKON_EN
      if (t_ir[2:0] == 3'b000) begin e_sk = ion_m; ion_m = 1'b0; delay_m = 1'b0; end
`endif
    end
    e_lat = (n == 0) ? 2 : 1 + n * (IOP + 1);
    if (mode == 2 || (mode == 1 && !is_ion)) delay_m = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " iot"}, bus.iot, 0);
    check({tag, " state"}, bus.state, 0);
    check({tag, " mb"}, bus.mb, 0);
    check({tag, " io_select"}, bus.io_select, 0);
    check({tag, " io_data_in"}, bus.io_data_in, 0);
    check({tag, " ac_out"}, bus.ac_out, 0);
    check({tag, " ac_load"}, bus.ac_load, 0);
    check({tag, " skip"}, bus.skip, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " int_req"}, bus.int_req, 0);
    $display("txn %s reset outputs checked", tag);
  endtask

  task automatic clear_rsp();
    rsp_clr = 3'b000; rsp_av = 3'b000; rsp_skp = 3'b000;
    for (int p = 0; p < 3; p++) rsp_data[p] = 12'o0;
  endtask

  initial begin
    logic [11:0] e_ac;
    logic        e_sk;
    int          e_lat, seen, k, mode;
    logic [5:0]  dev;
    logic [11:0] r_ir, r_ac;

    tbl[0] = '{ir:12'o6046, ac:12'o0101, clr:3'b000, av:3'b100, skp:3'b000,
               d0:12'o0, d1:12'o0, d2:12'o0033, e_ac:12'o0133, e_sk:1'b0, e_lat:7};
    tbl[1] = '{ir:12'o6031, ac:12'o1234, clr:3'b000, av:3'b000, skp:3'b001,
               d0:12'o0, d1:12'o0, d2:12'o0, e_ac:12'o1234, e_sk:1'b1, e_lat:4};
    tbl[2] = '{ir:12'o6036, ac:12'o7777, clr:3'b010, av:3'b100, skp:3'b000,
               d0:12'o0, d1:12'o0, d2:12'o0200, e_ac:12'o0200, e_sk:1'b0, e_lat:7};
    tbl[3] = '{ir:12'o6047, ac:12'o0070, clr:3'b010, av:3'b011, skp:3'b100,
               d0:12'o0001, d1:12'o0700, d2:12'o0, e_ac:12'o0700, e_sk:1'b1, e_lat:10};
    tbl[4] = '{ir:12'o6040, ac:12'o5555, clr:3'b111, av:3'b111, skp:3'b111,
               d0:12'o7777, d1:12'o7777, d2:12'o7777, e_ac:12'o5555, e_sk:1'b0, e_lat:2};
    tbl[5] = '{ir:12'o6054, ac:12'o4000, clr:3'b000, av:3'b100, skp:3'b100,
               d0:12'o0, d1:12'o0, d2:12'o0002, e_ac:12'o4002, e_sk:1'b1, e_lat:4};

    reset = 1'b0; bus.start = 1'b0; bus.ir = 12'o0; bus.ac_in = 12'o0;
    bus.instr_done = 1'b0; bus.io_interrupt = 1'b1;
    clear_rsp(); drive_rsp(4'h0);
    ion_m = 1'b0; delay_m = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1'b1;
    bus.io_interrupt = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rsp_clr = tbl[i].clr; rsp_av = tbl[i].av; rsp_skp = tbl[i].skp;
      rsp_data[0] = tbl[i].d0; rsp_data[1] = tbl[i].d1; rsp_data[2] = tbl[i].d2;
      run_iot(tbl[i].ir, tbl[i].ac, 0);
      check_txn($sformatf("vec%0d", i), tbl[i].ir, tbl[i].e_ac, tbl[i].e_sk, tbl[i].e_lat);
    end

    // ION is held off until an instr_done that follows the ION instruction.
    clear_rsp();
    bus.io_interrupt = 1'b1;
    model(12'o6001, 12'o0, 1, e_ac, e_sk, e_lat);
    run_iot(12'o6001, 12'o0, 1);
    check_txn("ion", 12'o6001, e_ac, e_sk, e_lat);
    seen = 0;
    for (int c = 1; c <= e_lat; c++) if (irq_log[c] !== 1'b0) seen++;
    check("ion int_req during ION", seen, 0);
    check("ion int_req after same-cycle instr_done", bus.int_req, 0);
    bus.instr_done = 1'b1;
    @(negedge clk);
    bus.instr_done = 1'b0;
    delay_m = 1'b0;
    check("ion int_req after next instr_done", bus.int_req, 1);
    model(12'o6002, 12'o0, 0, e_ac, e_sk, e_lat);
    run_iot(12'o6002, 12'o0, 0);
    check_txn("iof", 12'o6002, e_ac, e_sk, e_lat);
    check("iof int_req at P2 sample", irq_log[IOP], 1);
    check("iof int_req after P2 sample", irq_log[IOP + 1], 0);

    // Reset in the middle of P2 aborts the operation and clears ion.
    model(12'o6001, 12'o0, 2, e_ac, e_sk, e_lat);
    run_iot(12'o6001, 12'o0, 2);
    check("pre-reset int_req", bus.int_req, 1);
    rsp_clr = tbl[0].clr; rsp_av = tbl[0].av; rsp_skp = tbl[0].skp;
    rsp_data[0] = tbl[0].d0; rsp_data[1] = tbl[0].d1; rsp_data[2] = tbl[0].d2;
    @(negedge clk);
    bus.start = 1'b1; bus.ir = 12'o6046; bus.ac_in = 12'o0101;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.state !== 4'h2 && k < 20) begin @(negedge clk); k++; end
    check("rst reached P2", bus.state, 4'h2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset("midrst");
    ion_m = 1'b0; delay_m = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (bus.ac_load || bus.busy) seen++; end
    check("midrst no ac_load/busy", seen, 0);
    run_iot(tbl[0].ir, tbl[0].ac, 0);
    check_txn("after_rst", tbl[0].ir, tbl[0].e_ac, tbl[0].e_sk, tbl[0].e_lat);

    // 6000 with ion set: SKON when enabled, otherwise a no-op.
    clear_rsp();
    model(12'o6001, 12'o0, 2, e_ac, e_sk, e_lat);
    run_iot(12'o6001, 12'o0, 2);
    check("skon pre int_req", bus.int_req, 1);
    model(12'o6000, 12'o1357, 0, e_ac, e_sk, e_lat);
    run_iot(12'o6000, 12'o1357, 0);
    check_txn("6000", 12'o6000, e_ac, e_sk, e_lat);
    check("6000 int_req", bus.int_req, ion_m & ~delay_m);

    for (int i = 0; i < 40; i++) begin
      dev = ($urandom_range(0, 7) == 0) ? 6'o00 : 6'($urandom_range(1, 63));
      r_ir = {3'o6, dev, 3'($urandom)};
      r_ac = 12'($urandom);
      mode = $urandom_range(0, 2);
      rsp_clr = 3'($urandom); rsp_av = 3'($urandom); rsp_skp = 3'($urandom);
      for (int p = 0; p < 3; p++) rsp_data[p] = 12'($urandom);
      if (dev == 6'o00) clear_rsp();
      model(r_ir, r_ac, mode, e_ac, e_sk, e_lat);
      run_iot(r_ir, r_ac, mode);
      check_txn($sformatf("rnd%0d", i), r_ir, e_ac, e_sk, e_lat);
      bus.io_interrupt = 1'($urandom);
      @(negedge clk);
      check($sformatf("rnd%0d int_req", i), bus.int_req, ion_m & bus.io_interrupt & ~delay_m);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
